tx_buff_param: RTL and testbench
================================

TX_BUFF_PARAM -- requirements
Module: tx_buff_param

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_W, 8, byte width; SHALL be >= 5.
- HDR_BYTES, 2, header bytes per frame; SHALL be >= 1. The last header byte is the control byte.
- MAX_DATA, 8, maximum payload bytes; SHALL be >= 1.
- Derived: NBYTES = HDR_BYTES+MAX_DATA; CNT_W = clog2(NBYTES+1).

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- reset, in, 1, asynchronous, active-low reset.
- tx_buff_ld, in, 1, start-of-frame load request.
- data_in, in, DATA_W, byte from host.
- data_valid, in, 1, data_in valid.
- data_ready, out, 1, block accepts a byte this cycle.
- frame_ack, in, 1, frame generator has consumed the frame.
- abort, in, 1, cancel load or release frame.
- tx_buff_busy, out, 1, buffer owned by a load or pending frame.
- frame_rdy, out, 1, complete frame held.
- tx_buff, out, NBYTES*DATA_W, slot k at bits [k*DATA_W +: DATA_W].
- rtr, out, 1, remote request flag from the control byte.
- dlc, out, 4, raw data length code from the control byte.
- byte_cnt, out, CNT_W, bytes accepted in the current frame.
- load_err, out, 1, one-cycle pulse when a load is aborted.

Function
REQ-003 Transfer SHALL occur only on a rising clk edge with data_valid=1 and data_ready=1. data_ready SHALL be combinational from state only, =1 exactly in LOAD_HDR and LOAD_DATA.

REQ-004 FSM states SHALL be IDLE, LOAD_HDR, LOAD_DATA, READY.

REQ-005 IDLE:
- tx_buff_ld=1 SHALL clear all slots, byte_cnt, rtr and dlc to 0 and move to LOAD_HDR.
- data_valid SHALL be ignored.

REQ-006 The accepted byte SHALL be written to slot byte_cnt, and byte_cnt SHALL increment. Slots are indexed storage, not a shift chain: byte 0 stays in slot 0.

REQ-007 On acceptance of byte HDR_BYTES-1 (control byte):
- rtr <= data_in[4]; dlc <= data_in[3:0].
- Payload length PL SHALL be 0 if rtr=1, else min(dlc, MAX_DATA). dlc values 9-15 SHALL be clamped for PL only; the dlc output keeps the raw value.
- PL=0 -> READY; otherwise -> LOAD_DATA.

REQ-008 LOAD_DATA: acceptance of the byte that makes byte_cnt = HDR_BYTES+PL SHALL move to READY.

REQ-009 frame_rdy:
- SHALL be 1 exactly in READY, asserted the cycle after the last byte is accepted (1-cycle latency).
- Slots, rtr, dlc and byte_cnt SHALL be stable while in READY.

REQ-010 READY: frame_ack=1 SHALL move to IDLE. Slot contents, rtr, dlc and byte_cnt SHALL hold until the next tx_buff_ld.

REQ-011 tx_buff_busy SHALL be 1 in every state except IDLE.

REQ-012 tx_buff_ld outside IDLE SHALL be ignored. No restart and no error.

REQ-013 abort:
- In LOAD_HDR or LOAD_DATA: -> IDLE, all slots, byte_cnt, rtr and dlc cleared to 0, load_err pulsed for one cycle.
- In READY: -> IDLE with contents held, no load_err.
- In IDLE: no effect.

REQ-014 Simultaneous events:
- abort has priority over data transfer in the same cycle; the byte is discarded.
- abort and frame_ack together in READY behave as frame_ack.
- tx_buff_ld together with abort in IDLE SHALL start the load.

REQ-015 Unreachable state encodings SHALL return to IDLE on the next edge with outputs as in REQ-005.

Reset
REQ-016 reset=0 SHALL immediately, without waiting for clk, force:
- state IDLE;
- all slots, rtr, dlc, byte_cnt, frame_rdy, tx_buff_busy and load_err to 0.

REQ-017 Reset asserted mid-load or in READY SHALL discard the frame entirely. Operation SHALL resume on the first clk edge after reset=1.

Verification
REQ-018 Normal frame (defaults): ld; bytes 0xA1, 0x03, 0x11, 0x22, 0x33 -> frame_rdy=1 the cycle after 0x33; slots 0-4 = A1, 03, 11, 22, 33; slots 5-9 = 0; rtr=0; dlc=3; byte_cnt=5.

REQ-019 RTR frame: control byte 0x18 -> frame_rdy the cycle after byte 1; rtr=1; dlc=8; byte_cnt=2; no payload bytes accepted.

REQ-020 DLC clamp: control byte 0x0F then 8 payload bytes -> READY after the 8th byte; dlc=15; byte_cnt=10. A 9th data_valid is not accepted (data_ready=0).

REQ-021 Abort mid-load after 3 bytes -> load_err pulses for 1 cycle; IDLE; all slots 0; tx_buff_busy=0. A subsequent ld loads normally.

REQ-022 Backpressure and handshake:
- data_valid toggled randomly -> slots hold only bytes with valid=1.
- Hold READY 20 cycles without frame_ack -> contents stable and a ld pulse is ignored.
- frame_ack -> IDLE next cycle with tx_buff unchanged.

REQ-023 Asynchronous reset applied between clk edges mid-LOAD_DATA -> outputs clear before the next edge. After release, a new frame completes correctly.

Source files
------------

// File: rtl/tx_buff_param_if.sv
// ---------------------------------------------------------------------------
// tx_buff_param_if
// Groups the host-side byte handshake, frame-generator handshake and the
// frame buffer outputs of tx_buff_param into one bundle.
//   master modport : host / frame generator side (drives load, bytes, ack,
//                    abort; observes buffer and status)
//   slave modport  : the frame buffer itself
// Parameters must match the ones given to tx_buff_param.
// ---------------------------------------------------------------------------
interface tx_buff_param_if #(
    parameter int DATA_W    = 8,
    parameter int HDR_BYTES = 2,
    parameter int MAX_DATA  = 8
);
    localparam int NBYTES = HDR_BYTES + MAX_DATA;
    localparam int CNT_W  = $clog2(NBYTES + 1);

    logic                     tx_buff_ld;
    logic [DATA_W-1:0]        data_in;
    logic                     data_valid;
    logic                     data_ready;
    logic                     frame_ack;
    logic                     abort;
    logic                     tx_buff_busy;
    logic                     frame_rdy;
    logic [NBYTES*DATA_W-1:0] tx_buff;
    logic                     rtr;
    logic [3:0]               dlc;
    logic [CNT_W-1:0]         byte_cnt;
    logic                     load_err;

    modport master (
        output tx_buff_ld, data_in, data_valid, frame_ack, abort,
        input  data_ready, tx_buff_busy, frame_rdy, tx_buff, rtr, dlc,
               byte_cnt, load_err
    );

    modport slave (
        input  tx_buff_ld, data_in, data_valid, frame_ack, abort,
        output data_ready, tx_buff_busy, frame_rdy, tx_buff, rtr, dlc,
               byte_cnt, load_err
    );
endinterface

// File: rtl/tx_buff_param.sv
// ---------------------------------------------------------------------------
// tx_buff_param
// Frame assembly buffer. A host loads a frame byte by byte (header bytes,
// the last of which is the control byte, followed by a payload whose length
// comes from the control byte). The complete frame is then held for a frame
// generator until it acknowledges, or until the host aborts.
// Ports:
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : tx_buff_param_if.slave
//           tx_buff_ld  - start-of-frame load request (honoured in IDLE only)
//           data_in / data_valid / data_ready - byte handshake
//           frame_ack   - frame generator consumed the frame
//           abort       - cancel a load (clears) or release a frame (keeps)
//           tx_buff     - slot k at bits [k*DATA_W +: DATA_W]
//           rtr / dlc   - flags captured from the control byte
//           byte_cnt    - bytes accepted in the current frame
//           tx_buff_busy, frame_rdy, load_err - status
// ---------------------------------------------------------------------------
module tx_buff_param #(
    parameter int DATA_W    = 8,
    parameter int HDR_BYTES = 2,
    parameter int MAX_DATA  = 8
) (
    input  logic           clk,
    input  logic           reset,
    tx_buff_param_if.slave bus
);
    localparam int NBYTES = HDR_BYTES + MAX_DATA;
    localparam int CNT_W  = $clog2(NBYTES + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_BYTES - 1);
    localparam logic [CNT_W-1:0] HDR_LEN  = CNT_W'(HDR_BYTES);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_HDR  = 2'd1,
        LOAD_DATA = 2'd2,
        READY     = 2'd3
    } state_t;

    state_t                   state_r;
    state_t                   state_next_s;
    logic                     clear_s;
    logic                     accept_s;
    logic                     err_s;
    logic                     ctrl_byte_s;
    logic [CNT_W-1:0]         cnt_inc_s;
    logic [CNT_W-1:0]         pl_s;

    logic [NBYTES*DATA_W-1:0] tx_buff_r;
    logic [CNT_W-1:0]         byte_cnt_r;
    logic [CNT_W-1:0]         target_r;
    logic                     rtr_r;
    logic [3:0]               dlc_r;
    logic                     load_err_r;
    logic                     frame_rdy_r;
    logic                     busy_r;

    // Payload length from a control byte: zero for remote requests, else the
    // raw length code clamped to the payload capacity.
    function automatic logic [CNT_W-1:0] payload_len(input logic [DATA_W-1:0] ctrl);
        logic [31:0] dlc_v;
        dlc_v = {28'd0, ctrl[3:0]};
        if (ctrl[4]) begin
            payload_len = CNT_ZERO;
        end else if (dlc_v > 32'(MAX_DATA)) begin
            payload_len = CNT_W'(MAX_DATA);
        end else begin
            payload_len = CNT_W'(dlc_v);
        end
    endfunction

    assign cnt_inc_s   = byte_cnt_r + CNT_ONE;
    assign ctrl_byte_s = (byte_cnt_r == HDR_LAST);
    assign pl_s        = payload_len(bus.data_in);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and datapath control decode; abort outranks a byte transfer.
    always_comb begin
        state_next_s = state_r;
        clear_s      = 1'b0;
        accept_s     = 1'b0;
        err_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.tx_buff_ld) begin
                    clear_s      = 1'b1;
                    state_next_s = LOAD_HDR;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD_HDR: begin
                if (bus.abort) begin
                    clear_s      = 1'b1;
                    err_s        = 1'b1;
                    state_next_s = IDLE;
                end else if (bus.data_valid) begin
                    accept_s = 1'b1;
                    if (ctrl_byte_s) begin
                        if (pl_s == CNT_ZERO) begin
                            state_next_s = READY;
                        end else begin
                            state_next_s = LOAD_DATA;
                        end
                    end else begin
                        state_next_s = LOAD_HDR;
                    end
                end else begin
                    state_next_s = LOAD_HDR;
                end
            end
            LOAD_DATA: begin
                if (bus.abort) begin
                    clear_s      = 1'b1;
                    err_s        = 1'b1;
                    state_next_s = IDLE;
                end else if (bus.data_valid) begin
                    accept_s = 1'b1;
                    if (cnt_inc_s == target_r) begin
                        state_next_s = READY;
                    end else begin
                        state_next_s = LOAD_DATA;
                    end
                end else begin
                    state_next_s = LOAD_DATA;
                end
            end
            READY: begin
                // ack and abort both release the frame with contents kept
                if (bus.frame_ack || bus.abort) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = READY;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Frame storage, byte counter and control-byte fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_buff_r  <= {(NBYTES*DATA_W){1'b0}};
            byte_cnt_r <= CNT_ZERO;
            target_r   <= CNT_ZERO;
            rtr_r      <= 1'b0;
            dlc_r      <= 4'd0;
        end else if (clear_s) begin
            tx_buff_r  <= {(NBYTES*DATA_W){1'b0}};
            byte_cnt_r <= CNT_ZERO;
            target_r   <= CNT_ZERO;
            rtr_r      <= 1'b0;
            dlc_r      <= 4'd0;
        end else if (accept_s) begin
            // Indexed write: slot k only ever receives byte k.
            for (int k = 0; k < NBYTES; k++) begin
                if (byte_cnt_r == CNT_W'(k)) begin
                    tx_buff_r[k*DATA_W +: DATA_W] <= bus.data_in;
                end else begin
                    tx_buff_r[k*DATA_W +: DATA_W] <= tx_buff_r[k*DATA_W +: DATA_W];
                end
            end
            byte_cnt_r <= cnt_inc_s;
            if (ctrl_byte_s) begin
                rtr_r    <= bus.data_in[4];
                dlc_r    <= bus.data_in[3:0];
                target_r <= HDR_LEN + pl_s;
            end else begin
                rtr_r    <= rtr_r;
                dlc_r    <= dlc_r;
                target_r <= target_r;
            end
        end else begin
            tx_buff_r  <= tx_buff_r;
            byte_cnt_r <= byte_cnt_r;
            target_r   <= target_r;
            rtr_r      <= rtr_r;
            dlc_r      <= dlc_r;
        end
    end

    // Status flags registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_err_r  <= 1'b0;
            frame_rdy_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            load_err_r  <= err_s;
            frame_rdy_r <= (state_next_s == READY);
            busy_r      <= (state_next_s != IDLE);
        end
    end

    assign bus.data_ready   = (state_r == LOAD_HDR) || (state_r == LOAD_DATA);
    assign bus.tx_buff      = tx_buff_r;
    assign bus.byte_cnt     = byte_cnt_r;
    assign bus.rtr          = rtr_r;
    assign bus.dlc          = dlc_r;
    assign bus.load_err     = load_err_r;
    assign bus.frame_rdy    = frame_rdy_r;
    assign bus.tx_buff_busy = busy_r;

endmodule

// File: tb/tb_tx_buff_param.sv
// ---------------------------------------------------------------------------
// tb_tx_buff_param
// Directed bench for tx_buff_param with default parameters: a table of
// single-cycle vectors followed by hand-written multi-cycle sequences.
// ---------------------------------------------------------------------------
module tb_tx_buff_param;
    localparam int DATA_W    = 8;
    localparam int HDR_BYTES = 2;
    localparam int MAX_DATA  = 8;
    localparam int NBYTES    = HDR_BYTES + MAX_DATA;
    localparam int CNT_W     = $clog2(NBYTES + 1);
    localparam int BW        = NBYTES * DATA_W;

    logic clk;
    logic reset;

    tx_buff_param_if #(.DATA_W(DATA_W), .HDR_BYTES(HDR_BYTES), .MAX_DATA(MAX_DATA)) bus ();

    tx_buff_param #(.DATA_W(DATA_W), .HDR_BYTES(HDR_BYTES), .MAX_DATA(MAX_DATA)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    typedef struct packed {
        logic             ld;
        logic             valid;
        logic [7:0]       data;
        logic             ack;
        logic             abt;
        logic             e_dr;
        logic             e_rdy;
        logic             e_busy;
        logic             e_err;
        logic             e_rtr;
        logic [3:0]       e_dlc;
        logic [CNT_W-1:0] e_cnt;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.tx_buff_ld = 1'b0;
        bus.data_valid = 1'b0;
        bus.data_in    = 8'h00;
        bus.frame_ack  = 1'b0;
        bus.abort      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.data_valid = 1'b1;
        bus.data_in    = b;
        tick();
        bus.data_valid = 1'b0;
    endtask

    task automatic start_load();
        bus.tx_buff_ld = 1'b1;
        tick();
        bus.tx_buff_ld = 1'b0;
    endtask

    logic [BW-1:0] buf_snap;
    logic [BW-1:0] exp_buf;
    logic [7:0]    bp_bytes [7];
    int            accepted;
    int            cycles;
    logic          stable;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle_inputs();
        reset = 1'b0;
        #12;
        check("reset_state",
              {bus.data_ready, bus.frame_rdy, bus.tx_buff_busy, bus.load_err,
               bus.rtr, bus.dlc, bus.byte_cnt, bus.tx_buff},
              {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 80'h0});
        reset = 1'b1;
        @(negedge clk);

        //             ld    vld   data   ack   abt   dr    rdy   busy  err   rtr   dlc   cnt
        vecs[0]  = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
        vecs[1]  = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0};
        vecs[2]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1};
        vecs[3]  = '{1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd2};
        vecs[4]  = '{1'b0, 1'b0, 8'h5E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd2};
        vecs[5]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd3};
        vecs[6]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd4};
        vecs[7]  = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 4'd5};
        vecs[8]  = '{1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 4'd5};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 4'd5};
        vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0};
        vecs[11] = '{1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1};
        vecs[12] = '{1'b0, 1'b1, 8'h18, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd8, 4'd2};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8, 4'd2};
        vecs[14] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0};
        vecs[15] = '{1'b0, 1'b1, 8'hB0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1};
        vecs[16] = '{1'b0, 1'b1, 8'hB1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0};
        vecs[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};

        for (int i = 0; i < NV; i++) begin
            bus.tx_buff_ld = vecs[i].ld;
            bus.data_valid = vecs[i].valid;
            bus.data_in    = vecs[i].data;
            bus.frame_ack  = vecs[i].ack;
            bus.abort      = vecs[i].abt;
            tick();
            check($sformatf("vec%0d", i),
                  {bus.data_ready, bus.frame_rdy, bus.tx_buff_busy, bus.load_err,
                   bus.rtr, bus.dlc, bus.byte_cnt},
                  {vecs[i].e_dr, vecs[i].e_rdy, vecs[i].e_busy, vecs[i].e_err,
                   vecs[i].e_rtr, vecs[i].e_dlc, vecs[i].e_cnt});
        end
        idle_inputs();
        tick();

        // Normal frame, then a long hold in READY, then acknowledge.
        start_load();
        send_byte(8'hA1);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        check("normal_not_yet_rdy", {127'd0, bus.frame_rdy}, 128'd0);
        send_byte(8'h33);
        check("normal_rdy", {bus.frame_rdy, bus.rtr, bus.dlc, bus.byte_cnt},
              {1'b1, 1'b0, 4'd3, 4'd5});
        check("normal_buff", {48'd0, bus.tx_buff}, {48'd0, 80'h0000_0000_0033_2211_03A1});
        buf_snap = bus.tx_buff;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.tx_buff_ld = (i == 10);
            bus.data_valid = 1'($urandom_range(0, 1));
            bus.data_in    = 8'($urandom);
            tick();
            if (bus.tx_buff !== buf_snap || bus.frame_rdy !== 1'b1 ||
                bus.byte_cnt !== 4'd5 || bus.data_ready !== 1'b0) begin
                stable = 1'b0;
            end
        end
        idle_inputs();
        check("hold_ready_stable", {127'd0, stable}, {127'd0, 1'b1});
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;
        check("ack_idle", {bus.frame_rdy, bus.tx_buff_busy, bus.data_ready, bus.tx_buff},
              {1'b0, 1'b0, 1'b0, 80'h0000_0000_0033_2211_03A1});

        // Length code above capacity: payload clamps, dlc stays raw.
        start_load();
        send_byte(8'h00);
        send_byte(8'h0F);
        for (int i = 1; i <= 7; i++) send_byte(8'(i));
        check("clamp_before_last", {bus.frame_rdy, bus.byte_cnt}, {1'b0, 4'd9});
        send_byte(8'h08);
        check("clamp_rdy", {bus.frame_rdy, bus.dlc, bus.byte_cnt, bus.rtr},
              {1'b1, 4'd15, 4'd10, 1'b0});
        bus.data_valid = 1'b1;
        bus.data_in    = 8'h99;
        #1;
        check("clamp_no_ready", {127'd0, bus.data_ready}, 128'd0);
        tick();
        bus.data_valid = 1'b0;
        check("clamp_buff", {48'd0, bus.tx_buff}, {48'd0, 80'h0807_0605_0403_0201_0F00});
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;

        // Random data_valid: only bytes presented with valid land in slots.
        bp_bytes[0] = 8'hC0; bp_bytes[1] = 8'h05; bp_bytes[2] = 8'hD1;
        bp_bytes[3] = 8'hD2; bp_bytes[4] = 8'hD3; bp_bytes[5] = 8'hD4;
        bp_bytes[6] = 8'hD5;
        exp_buf = '0;
        for (int k = 0; k < 7; k++) exp_buf[k*8 +: 8] = bp_bytes[k];
        start_load();
        accepted = 0;
        cycles   = 0;
        while (accepted < 7 && cycles < 80) begin
            if ($urandom_range(0, 2) != 0) begin
                bus.data_valid = 1'b1;
                bus.data_in    = bp_bytes[accepted];
                accepted++;
            end else begin
                bus.data_valid = 1'b0;
                bus.data_in    = 8'($urandom);
            end
            tick();
            cycles++;
        end
        idle_inputs();
        check("bp_done_in_budget", {127'd0, (accepted == 7)}, {127'd0, 1'b1});
        check("bp_frame", {bus.frame_rdy, bus.byte_cnt, bus.dlc}, {1'b1, 4'd7, 4'd5});
        check("bp_buff", {48'd0, bus.tx_buff}, {48'd0, exp_buf});
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;

        // Abort after three bytes, then a clean reload.
        start_load();
        send_byte(8'hC0);
        send_byte(8'h02);
        send_byte(8'hE1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_pulse", {bus.load_err, bus.tx_buff_busy, bus.byte_cnt, bus.tx_buff},
              {1'b1, 1'b0, 4'd0, 80'h0});
        tick();
        check("abort_pulse_end", {127'd0, bus.load_err}, 128'd0);
        start_load();
        send_byte(8'h12);
        send_byte(8'h00);
        check("reload_rdy", {bus.frame_rdy, bus.byte_cnt, bus.tx_buff},
              {1'b1, 4'd2, 80'h0000_0000_0000_0000_0012});
        bus.frame_ack = 1'b1;
        tick();
        bus.frame_ack = 1'b0;

        // Asynchronous reset between edges in the middle of the payload.
        start_load();
        send_byte(8'h01);
        send_byte(8'h04);
        send_byte(8'hAA);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", {bus.tx_buff_busy, bus.data_ready, bus.frame_rdy,
                              bus.byte_cnt, bus.dlc, bus.tx_buff},
              {1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 80'h0});
        #2;
        reset = 1'b1;
        tick();
        start_load();
        send_byte(8'h5A);
        send_byte(8'h01);
        send_byte(8'h6B);
        check("after_reset_frame", {bus.frame_rdy, bus.byte_cnt, bus.tx_buff},
              {1'b1, 4'd3, 80'h0000_0000_0000_006B_015A});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
